// File: rtl/pwm_ramp_ctrl.sv
// Purpose: slews the PWM on-time toward a commanded target in bounded steps, aligned to period boundaries.
// Latency: a command is accepted in one cycle; ton moves one step every RAMP_DIV periods; estop zeroes ton on the next edge.
// Backpressure: o_cmd_ready drops only while stopped (and in reset); a new command may override the target mid-ramp.
module pwm_ramp_ctrl #(
    parameter int  T        = 1000,
    parameter int  STEP     = 1,
    parameter int  RAMP_DIV = 4,
    localparam int W        = $clog2(T)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_cmd_valid,
    output logic         o_cmd_ready,
    input  logic [W-1:0] i_cmd_ton,
    input  logic         i_estop,
    output logic [W-1:0] o_ton,
    output logic         o_period_start,
    output logic         o_busy,
    output logic         o_at_target
);

    // Largest on-time representable and meaningful for the period.
    localparam int TMAX = (T < (2**W) - 1) ? T : (2**W) - 1;
    // Ramp divider width; at least one bit even when every boundary steps.
    localparam int RDW  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    localparam logic [W-1:0]   PCNT_LAST = W'(T - 1);
    localparam logic [W-1:0]   TMAX_W    = W'(TMAX);
    localparam logic [W:0]     STEP_V    = (W+1)'(STEP);
    localparam logic [RDW-1:0] RDIV_LAST = RDW'(RAMP_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    state_t         r_state;
    logic [W-1:0]   r_pcnt;
    logic [W-1:0]   r_ton;
    logic [W-1:0]   r_target;
    logic [RDW-1:0] r_rdiv;

    state_t         w_state_nxt;
    logic [W-1:0]   w_ton_nxt;
    logic [W-1:0]   w_target_nxt;
    logic [RDW-1:0] w_rdiv_nxt;

    logic           w_accept;
    logic [W-1:0]   w_cmd_clamped;
    logic           w_up;
    logic [W:0]     w_diff;
    logic [W:0]     w_mag;
    logic [W-1:0]   w_ton_step;
    logic           w_unused_carry;

    // Handshake and status outputs; reset forces the quiescent view.
    assign o_cmd_ready    = !i_rst && (r_state != ST_STOP);
    assign o_period_start = !i_rst && (r_pcnt == PCNT_LAST);
    assign o_busy         = !i_rst && (r_state == ST_RAMP);
    assign o_at_target    = i_rst || (r_state == ST_IDLE);
    assign o_ton          = r_ton;

    assign w_accept      = i_cmd_valid && o_cmd_ready;
    assign w_cmd_clamped = (i_cmd_ton > TMAX_W) ? TMAX_W : i_cmd_ton;

    // One step toward the registered target, never past it; the carry bit
    // cannot be set because the result always lies between ton and target.
    assign w_up   = (r_target > r_ton);
    assign w_diff = w_up ? ({1'b0, r_target} - {1'b0, r_ton})
                         : ({1'b0, r_ton} - {1'b0, r_target});
    assign w_mag  = (w_diff < STEP_V) ? w_diff : STEP_V;
    assign {w_unused_carry, w_ton_step} = w_up ? ({1'b0, r_ton} + w_mag)
                                               : ({1'b0, r_ton} - w_mag);

    // Period counter, phase-locked to pwmgen through the shared reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pcnt <= '0;
        end else if (r_pcnt == PCNT_LAST) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + W'(1);
        end
    end

    // Next-state logic: estop overrides stepping, stepping coexists with a new command.
    always_comb begin
        w_state_nxt  = r_state;
        w_ton_nxt    = r_ton;
        w_target_nxt = r_target;
        w_rdiv_nxt   = r_rdiv;

        if (w_accept) begin
            w_target_nxt = w_cmd_clamped;
        end

        case (r_state)
            ST_IDLE: begin
                w_rdiv_nxt = '0;
                if (r_target != r_ton) begin
                    w_state_nxt = ST_RAMP;
                end
            end
            ST_RAMP: begin
                if (r_ton == r_target) begin
                    w_state_nxt = ST_IDLE;
                    w_rdiv_nxt  = '0;
                end else if (o_period_start) begin
                    if (r_rdiv == RDIV_LAST) begin
                        w_rdiv_nxt = '0;
                        w_ton_nxt  = w_ton_step;
                    end else begin
                        w_rdiv_nxt = r_rdiv + RDW'(1);
                    end
                end
            end
            ST_STOP: begin
                // ton/target/rdiv were already cleared on entry
                if (!i_estop) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (i_estop) begin
            w_state_nxt  = ST_STOP;
            w_ton_nxt    = '0;
            w_target_nxt = '0;
            w_rdiv_nxt   = '0;
        end
    end

    // State register for the sequencer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_ton    <= '0;
            r_target <= '0;
            r_rdiv   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_ton    <= w_ton_nxt;
            r_target <= w_target_nxt;
            r_rdiv   <= w_rdiv_nxt;
        end
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Purpose: checks pwm_ramp_ctrl against a cycle-level reference built from the ramp rules.
// Latency: inputs driven after the falling edge, outputs sampled 1 time unit later.
// Backpressure: commands are offered only as single-cycle pulses; the model decides acceptance.
module tb_pwm_ramp_ctrl;

    localparam int T    = 10;
    localparam int STEP = 2;
    localparam int RDIV = 2;
    localparam int TMAX = 10;

    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_cmd_valid = 1'b0;
    logic [3:0] i_cmd_ton = 4'd0;
    logic       i_estop = 1'b0;
    logic       o_cmd_ready;
    logic [3:0] o_ton;
    logic       o_period_start;
    logic       o_busy;
    logic       o_at_target;

    logic       b_rst = 1'b1;
    logic       b_valid = 1'b0;
    logic [3:0] b_cmd = 4'd0;
    logic       b_estop = 1'b0;
    logic       b_ready;
    logic [3:0] b_ton;
    logic       b_ps;
    logic       b_busy;
    logic       b_at;

    always #5 clk = ~clk;

    pwm_ramp_ctrl #(.T(T), .STEP(STEP), .RAMP_DIV(RDIV)) u_dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .i_cmd_valid    (i_cmd_valid),
        .o_cmd_ready    (o_cmd_ready),
        .i_cmd_ton      (i_cmd_ton),
        .i_estop        (i_estop),
        .o_ton          (o_ton),
        .o_period_start (o_period_start),
        .o_busy         (o_busy),
        .o_at_target    (o_at_target)
    );

    pwm_ramp_ctrl #(.T(16), .STEP(2), .RAMP_DIV(1)) u_dut16 (
        .i_clk          (clk),
        .i_rst          (b_rst),
        .i_cmd_valid    (b_valid),
        .o_cmd_ready    (b_ready),
        .i_cmd_ton      (b_cmd),
        .i_estop        (b_estop),
        .o_ton          (b_ton),
        .o_period_start (b_ps),
        .o_busy         (b_busy),
        .o_at_target    (b_at)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: period position, output/target on-times, boundaries since last step,
    // and mode (0 settled, 1 ramping, 2 stopped).
    int m_pcnt = 0, m_ton = 0, m_target = 0, m_bcnt = 0, m_mode = 0;

    // Last sampled DUT outputs and history for the boundary-only invariant.
    int s_ton = 0, s_rdy = 0, s_ps = 0, s_busy = 0, s_at = 0;
    int prev_ton = 0;
    bit prev_ps = 1'b0, prev_quiet = 1'b0;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cycle(input bit rst, input bit vld, input int cmd, input bit est);
        int  e_rdy, e_ps, e_busy, e_at, ntgt, d;
        bit  boundary;
        @(negedge clk);
        i_rst       = rst;
        i_cmd_valid = vld;
        i_cmd_ton   = cmd[3:0];
        i_estop     = est;
        #1;
        s_ton = int'(o_ton); s_rdy = int'(o_cmd_ready); s_ps = int'(o_period_start);
        s_busy = int'(o_busy); s_at = int'(o_at_target);

        e_ps   = (!rst && m_pcnt == T - 1) ? 1 : 0;
        e_rdy  = (!rst && m_mode != 2) ? 1 : 0;
        e_busy = (!rst && m_mode == 1) ? 1 : 0;
        e_at   = (rst || m_mode == 0) ? 1 : 0;
        check("ton", s_ton, m_ton);
        check("cmd_ready", s_rdy, e_rdy);
        check("period_start", s_ps, e_ps);
        check("busy", s_busy, e_busy);
        check("at_target", s_at, e_at);

        // ton may only move on a boundary, and then by at most STEP
        if (prev_quiet) begin
            if (!prev_ps) check("hold_off_boundary", s_ton, prev_ton);
            else check("step_bound", ((s_ton - prev_ton) <= STEP && (prev_ton - s_ton) <= STEP) ? 1 : 0, 1);
        end
        prev_ton   = s_ton;
        prev_ps    = (e_ps != 0);
        prev_quiet = !rst && !est;

        // advance the reference across the coming rising edge
        if (rst) begin
            m_pcnt = 0; m_ton = 0; m_target = 0; m_bcnt = 0; m_mode = 0;
        end else begin
            ntgt = m_target;
            if (vld && e_rdy != 0) ntgt = (cmd > TMAX) ? TMAX : cmd;
            boundary = (m_pcnt == T - 1);
            m_pcnt = (m_pcnt + 1) % T;
            if (est) begin
                m_ton = 0; ntgt = 0; m_bcnt = 0; m_mode = 2;
            end else if (m_mode == 2) begin
                m_mode = 0;
            end else if (m_mode == 0) begin
                if (m_target != m_ton) m_mode = 1;
            end else if (m_ton == m_target) begin
                m_mode = 0; m_bcnt = 0;
            end else if (boundary) begin
                m_bcnt++;
                if (m_bcnt == RDIV) begin
                    m_bcnt = 0;
                    d = m_target - m_ton;
                    if (d > STEP)  d = STEP;
                    if (d < -STEP) d = -STEP;
                    m_ton = m_ton + d;
                end
            end
            m_target = ntgt;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        bit seen_above;
        bit est;
        @(posedge clk);

        // 1: reset, then first boundary on the 10th cycle after release
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            cycle(1'b0, 1'b0, 0, 1'b0);
            check("s1_first_ps", s_ps, (k == 10) ? 1 : 0);
        end
        idle(10);
        check("s1_ps_period", s_ps, 1);

        // 2: ramp 0 -> 7
        cycle(1'b0, 1'b1, 7, 1'b0);
        idle(120);
        check("s2_ton", s_ton, 7);
        check("s2_at_target", s_at, 1);

        // 3: redirect a ramp toward 8 down to 3 while ton is 4
        cycle(1'b0, 1'b1, 0, 1'b0);
        idle(100);
        cycle(1'b0, 1'b1, 8, 1'b0);
        for (int k = 0; k < 200 && m_ton != 4; k++) cycle(1'b0, 1'b0, 0, 1'b0);
        check("s3_reach4", m_ton, 4);
        cycle(1'b0, 1'b1, 3, 1'b0);
        seen_above = 1'b0;
        for (int k = 0; k < 100; k++) begin
            cycle(1'b0, 1'b0, 0, 1'b0);
            if (s_ton > 4) seen_above = 1'b1;
        end
        check("s3_no_rise", int'(seen_above), 0);
        check("s3_ton", s_ton, 3);

        // 4: request above TMAX clamps to 10
        cycle(1'b0, 1'b1, 15, 1'b0);
        idle(120);
        check("s4_ton_clamped", s_ton, 10);

        // 5: estop mid-ramp at pcnt 3 while a command is offered
        cycle(1'b0, 1'b1, 0, 1'b0);
        for (int k = 0; k < 60 && !(m_mode == 1 && m_pcnt == 3); k++) cycle(1'b0, 1'b0, 0, 1'b0);
        check("s5_pcnt3", m_pcnt, 3);
        cycle(1'b0, 1'b1, 9, 1'b1);
        cycle(1'b0, 1'b1, 9, 1'b1);
        check("s5_ton_zero", s_ton, 0);
        check("s5_not_ready", s_rdy, 0);
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 9, 1'b1);
        cycle(1'b0, 1'b0, 0, 1'b0);
        cycle(1'b0, 1'b0, 0, 1'b0);
        check("s5_ready_again", s_rdy, 1);
        check("s5_idle", s_at, 1);
        idle(30);
        check("s5_ton_still0", s_ton, 0);

        // 6: reset mid-ramp, then command on a boundary cycle
        cycle(1'b0, 1'b1, 10, 1'b0);
        for (int k = 0; k < 200 && m_ton != 6; k++) cycle(1'b0, 1'b0, 0, 1'b0);
        check("s6_reach6", m_ton, 6);
        cycle(1'b1, 1'b0, 0, 1'b0);
        cycle(1'b0, 1'b0, 0, 1'b0);
        check("s6_ton_reset", s_ton, 0);
        for (int k = 0; k < 12 && m_pcnt != T - 1; k++) cycle(1'b0, 1'b0, 0, 1'b0);
        cycle(1'b0, 1'b1, 5, 1'b0);
        check("s6_cmd_on_ps", s_ps, 1);
        idle(100);
        check("s6_ton", s_ton, 5);

        // random traffic
        est = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (est) est = ($urandom_range(0, 5) != 0);
            else     est = ($urandom_range(0, 299) == 0);
            cycle($urandom_range(0, 599) == 0, $urandom_range(0, 29) == 0,
                  int'($urandom_range(0, 15)), est);
        end

        // T=16: full-scale request reaches 15
        @(negedge clk);
        b_rst = 1'b0; b_valid = 1'b1; b_cmd = 4'd15;
        @(negedge clk);
        b_valid = 1'b0;
        repeat (250) @(negedge clk);
        #1;
        check("t16_ton", int'(b_ton), 15);
        check("t16_at_target", int'(b_at), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
